// File: rtl/uart_bus_arbiter.sv
// Two-master Wishbone arbiter in front of a single UART slave. It grants round-robin,
// locks the bus for the whole master cycle and times out slaves that never ACK.
module uart_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTN,
  input  logic                  i_M0_CYC,
  input  logic                  i_M0_STB,
  input  logic                  i_M0_WE,
  input  logic [ADDR_WIDTH-1:0] i_M0_ADDR,
  input  logic [DATA_WIDTH-1:0] i_M0_DATA,
  input  logic [3:0]            i_M0_SEL,
  output logic [DATA_WIDTH-1:0] o_M0_DATA,
  output logic                  o_M0_ACK,
  output logic                  o_M0_ERR,
  input  logic                  i_M1_CYC,
  input  logic                  i_M1_STB,
  input  logic                  i_M1_WE,
  input  logic [ADDR_WIDTH-1:0] i_M1_ADDR,
  input  logic [DATA_WIDTH-1:0] i_M1_DATA,
  input  logic [3:0]            i_M1_SEL,
  output logic [DATA_WIDTH-1:0] o_M1_DATA,
  output logic                  o_M1_ACK,
  output logic                  o_M1_ERR,
  output logic                  o_S_CYC,
  output logic                  o_S_STB,
  output logic                  o_S_WE,
  output logic [ADDR_WIDTH-1:0] o_S_ADDR,
  output logic [DATA_WIDTH-1:0] o_S_DATA,
  output logic [3:0]            o_S_SEL,
  input  logic [DATA_WIDTH-1:0] i_S_DATA,
  input  logic                  i_S_ACK,
  output logic [1:0]            o_GNT,
  output logic [7:0]            o_ERR_CNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic                  last_gnt;
  logic [15:0]           wait_cnt;
  logic [7:0]            err_cnt;
  logic                  req0, req1;
  logic                  g_cyc, g_stb, g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [3:0]            g_sel;
  logic                  timeout;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign req0 = i_M0_CYC & i_M0_STB;
  assign req1 = i_M1_CYC & i_M1_STB;

  // last_gnt resets to master 1 so that master 0 wins the first tie
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == GNT0 && !i_M0_CYC) last_gnt <= 1'b0;
      if (state == GNT1 && !i_M1_CYC) last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last_gnt ? GNT0 : GNT1;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0:    if (!i_M0_CYC) state_nxt = IDLE;
      GNT1:    if (!i_M1_CYC) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    g_sel  = '0;
    if (state == GNT0) begin
      g_cyc = i_M0_CYC; g_stb = i_M0_STB; g_we = i_M0_WE;
      g_addr = i_M0_ADDR; g_data = i_M0_DATA; g_sel = i_M0_SEL;
    end else if (state == GNT1) begin
      g_cyc = i_M1_CYC; g_stb = i_M1_STB; g_we = i_M1_WE;
      g_addr = i_M1_ADDR; g_data = i_M1_DATA; g_sel = i_M1_SEL;
    end
  end

  // ACK in the limit cycle suppresses the timeout
  assign timeout = g_stb && !i_S_ACK && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    o_S_CYC   = g_cyc;
    o_S_STB   = g_stb & ~timeout;
    o_S_WE    = g_we;
    o_S_ADDR  = g_addr;
    o_S_DATA  = g_data;
    o_S_SEL   = g_sel;
    o_M0_ACK  = i_S_ACK & (state == GNT0);
    o_M1_ACK  = i_S_ACK & (state == GNT1);
    o_M0_ERR  = timeout & (state == GNT0);
    o_M1_ERR  = timeout & (state == GNT1);
    o_M0_DATA = (state == GNT0) ? i_S_DATA : '0;
    o_M1_DATA = (state == GNT1) ? i_S_DATA : '0;
    o_GNT     = {state == GNT1, state == GNT0};
    o_ERR_CNT = err_cnt;
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      wait_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == IDLE || i_S_ACK || !g_stb || timeout) wait_cnt <= '0;
      else                                               wait_cnt <= wait_cnt + 16'd1;
      if (timeout) err_cnt <= sat_inc8(err_cnt);
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scenario bench for uart_bus_arbiter with a short timeout; expected read/write data
// goes through a queue and is compared when the DUT presents it.
module tb_uart_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          i_CLK = 1'b0;
  logic          i_RSTN;
  logic          i_M0_CYC, i_M0_STB, i_M0_WE;
  logic [AW-1:0] i_M0_ADDR;
  logic [DW-1:0] i_M0_DATA;
  logic [3:0]    i_M0_SEL;
  logic [DW-1:0] o_M0_DATA;
  logic          o_M0_ACK, o_M0_ERR;
  logic          i_M1_CYC, i_M1_STB, i_M1_WE;
  logic [AW-1:0] i_M1_ADDR;
  logic [DW-1:0] i_M1_DATA;
  logic [3:0]    i_M1_SEL;
  logic [DW-1:0] o_M1_DATA;
  logic          o_M1_ACK, o_M1_ERR;
  logic          o_S_CYC, o_S_STB, o_S_WE;
  logic [AW-1:0] o_S_ADDR;
  logic [DW-1:0] o_S_DATA;
  logic [3:0]    o_S_SEL;
  logic [DW-1:0] i_S_DATA;
  logic          i_S_ACK;
  logic [1:0]    o_GNT;
  logic [7:0]    o_ERR_CNT;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;
  logic [7:0]    exp_cnt;

  always #5 i_CLK = ~i_CLK;

  uart_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_CLK(i_CLK), .i_RSTN(i_RSTN),
    .i_M0_CYC(i_M0_CYC), .i_M0_STB(i_M0_STB), .i_M0_WE(i_M0_WE),
    .i_M0_ADDR(i_M0_ADDR), .i_M0_DATA(i_M0_DATA), .i_M0_SEL(i_M0_SEL),
    .o_M0_DATA(o_M0_DATA), .o_M0_ACK(o_M0_ACK), .o_M0_ERR(o_M0_ERR),
    .i_M1_CYC(i_M1_CYC), .i_M1_STB(i_M1_STB), .i_M1_WE(i_M1_WE),
    .i_M1_ADDR(i_M1_ADDR), .i_M1_DATA(i_M1_DATA), .i_M1_SEL(i_M1_SEL),
    .o_M1_DATA(o_M1_DATA), .o_M1_ACK(o_M1_ACK), .o_M1_ERR(o_M1_ERR),
    .o_S_CYC(o_S_CYC), .o_S_STB(o_S_STB), .o_S_WE(o_S_WE),
    .o_S_ADDR(o_S_ADDR), .o_S_DATA(o_S_DATA), .o_S_SEL(o_S_SEL),
    .i_S_DATA(i_S_DATA), .i_S_ACK(i_S_ACK),
    .o_GNT(o_GNT), .o_ERR_CNT(o_ERR_CNT)
  );

  function automatic logic [7:0] model_sat(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  task automatic step();
    @(posedge i_CLK);
    #2;
  endtask

  task automatic test_reset();
    i_RSTN = 1'b0;
    i_M0_CYC = 0; i_M0_STB = 0; i_M0_WE = 0; i_M0_ADDR = '0; i_M0_DATA = '0; i_M0_SEL = '0;
    i_M1_CYC = 0; i_M1_STB = 0; i_M1_WE = 0; i_M1_ADDR = '0; i_M1_DATA = '0; i_M1_SEL = '0;
    i_S_DATA = '0; i_S_ACK = 1'b0;
    exp_cnt = 8'd0;
    #1;
    n_vec++; if (o_GNT !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", o_GNT); end
    n_vec++; if ({o_S_CYC, o_S_STB, o_S_WE} !== 3'b000) begin n_err++; $display("FAIL rst_s_ctl: got %b want 000", {o_S_CYC, o_S_STB, o_S_WE}); end
    n_vec++; if (o_ERR_CNT !== 8'd0) begin n_err++; $display("FAIL rst_errcnt: got %0d want 0", o_ERR_CNT); end
    n_vec++; if ({o_M0_ACK, o_M0_ERR, o_M1_ACK, o_M1_ERR} !== 4'b0000) begin n_err++; $display("FAIL rst_resp: got %b want 0000", {o_M0_ACK, o_M0_ERR, o_M1_ACK, o_M1_ERR}); end
    step(); step();
    i_RSTN = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    i_M0_CYC = 1; i_M0_STB = 1; i_M0_WE = 0; i_M0_ADDR = 32'h0000_0010; i_M0_SEL = 4'hF;
    #1;
    n_vec++; if (o_GNT !== 2'b00) begin n_err++; $display("FAIL rd_idle_gnt: got %b want 00", o_GNT); end
    step();
    n_vec++; if (o_GNT !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b want 01", o_GNT); end
    n_vec++; if (o_S_ADDR !== 32'h10 || o_S_STB !== 1'b1 || o_S_SEL !== 4'hF) begin n_err++; $display("FAIL rd_mirror: got addr %h stb %b sel %h want 10 1 f", o_S_ADDR, o_S_STB, o_S_SEL); end
    step();
    // slave answers while the master drops CYC in the same cycle
    i_S_ACK = 1'b1; i_S_DATA = 32'h41; exp_q.push_back(32'h0000_0041);
    i_M0_CYC = 0; i_M0_STB = 0;
    #1;
    n_vec++; if (o_M0_ACK !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", o_M0_ACK); end
    if (o_M0_ACK === 1'b1 && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      n_vec++; if (o_M0_DATA !== exp_d) begin n_err++; $display("FAIL rd_data: got %h want %h", o_M0_DATA, exp_d); end
    end
    n_vec++; if (o_M1_DATA !== '0 || o_M1_ACK !== 1'b0) begin n_err++; $display("FAIL rd_m1_quiet: got data %h ack %b want 0 0", o_M1_DATA, o_M1_ACK); end
    step();
    i_S_ACK = 1'b0; i_S_DATA = '0;
    #1;
    n_vec++; if (o_GNT !== 2'b00) begin n_err++; $display("FAIL rd_back_idle: got %b want 00", o_GNT); end
    exp_q.delete();
  endtask

  task automatic test_contention();
    i_RSTN = 1'b0; #1; i_RSTN = 1'b1;
    i_M0_CYC = 1; i_M0_STB = 1; i_M0_ADDR = 32'hA0;
    i_M1_CYC = 1; i_M1_STB = 1; i_M1_ADDR = 32'hB1;
    step();
    n_vec++; if (o_GNT !== 2'b01) begin n_err++; $display("FAIL cont_first: got %b want 01", o_GNT); end
    i_S_ACK = 1'b1;
    #1;
    n_vec++; if (o_M0_ACK !== 1'b1 || o_M1_ACK !== 1'b0) begin n_err++; $display("FAIL cont_ack: got m0 %b m1 %b want 1 0", o_M0_ACK, o_M1_ACK); end
    i_S_ACK = 1'b0; i_M0_CYC = 0; i_M0_STB = 0;
    step();
    n_vec++; if (o_GNT !== 2'b00) begin n_err++; $display("FAIL cont_gap: got %b want 00", o_GNT); end
    i_M0_CYC = 1; i_M0_STB = 1;
    step();
    n_vec++; if (o_GNT !== 2'b10) begin n_err++; $display("FAIL cont_rr: got %b want 10", o_GNT); end
    n_vec++; if (o_S_ADDR !== 32'hB1) begin n_err++; $display("FAIL cont_m1_addr: got %h want b1", o_S_ADDR); end
    i_M0_CYC = 0; i_M0_STB = 0; i_M1_CYC = 0; i_M1_STB = 0;
    step();
  endtask

  task automatic test_lock();
    logic [DW-1:0] wr [3];
    int seen;
    wr[0] = 32'h48; wr[1] = 32'h69; wr[2] = 32'h0A;
    seen = 0;
    i_M1_CYC = 1; i_M1_STB = 1; i_M1_WE = 0;
    i_M0_CYC = 1; i_M0_STB = 1; i_M0_WE = 1; i_M0_DATA = wr[0];
    step();
    for (int i = 0; i < 3; i++) begin
      i_M0_STB = 1; i_M0_DATA = wr[i]; exp_q.push_back(wr[i]);
      i_S_ACK = 1'b1;
      #1;
      if (o_S_STB === 1'b1 && i_S_ACK === 1'b1 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        seen++;
        n_vec++; if (o_S_DATA !== exp_d || o_S_WE !== 1'b1) begin n_err++; $display("FAIL lock_wr%0d: got %h we %b want %h we 1", i, o_S_DATA, o_S_WE, exp_d); end
      end
      n_vec++; if (o_M1_ACK !== 1'b0 || o_GNT !== 2'b01) begin n_err++; $display("FAIL lock_hold%0d: got m1ack %b gnt %b want 0 01", i, o_M1_ACK, o_GNT); end
      step();
      i_S_ACK = 1'b0; i_M0_STB = 0;
      step();
    end
    n_vec++; if (seen !== 3) begin n_err++; $display("FAIL lock_count: got %0d want 3", seen); end
    i_M0_CYC = 0; i_M0_WE = 0;
    step();
    n_vec++; if (o_GNT !== 2'b00 || o_M1_ACK !== 1'b0) begin n_err++; $display("FAIL lock_release: got gnt %b m1ack %b want 00 0", o_GNT, o_M1_ACK); end
    step();
    n_vec++; if (o_GNT !== 2'b10) begin n_err++; $display("FAIL lock_m1_gnt: got %b want 10", o_GNT); end
    i_M1_CYC = 0; i_M1_STB = 0;
    step();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    i_M0_CYC = 1; i_M0_STB = 1;
    step();
    for (int k = 0; k <= TO; k++) begin
      n_vec++; if (o_M0_ERR !== (k == TO - 1) || o_S_STB !== (k != TO - 1)) begin n_err++; $display("FAIL to_cyc%0d: got err %b stb %b want %b %b", k, o_M0_ERR, o_S_STB, k == TO - 1, k != TO - 1); end
      if (o_M0_ERR === 1'b1) exp_cnt = model_sat(exp_cnt);
      step();
    end
    n_vec++; if (o_ERR_CNT !== exp_cnt) begin n_err++; $display("FAIL to_errcnt: got %0d want %0d", o_ERR_CNT, exp_cnt); end
    i_M0_CYC = 0; i_M0_STB = 0;
    step();
  endtask

  task automatic test_ack_at_limit();
    i_M0_CYC = 1; i_M0_STB = 1;
    step();
    for (int k = 0; k < TO - 1; k++) step();
    i_S_ACK = 1'b1; i_S_DATA = 32'h55;
    #1;
    n_vec++; if (o_M0_ACK !== 1'b1 || o_M0_ERR !== 1'b0 || o_S_STB !== 1'b1) begin n_err++; $display("FAIL lim_ack: got ack %b err %b stb %b want 1 0 1", o_M0_ACK, o_M0_ERR, o_S_STB); end
    step();
    i_S_ACK = 1'b0;
    #1;
    n_vec++; if (o_ERR_CNT !== exp_cnt) begin n_err++; $display("FAIL lim_errcnt: got %0d want %0d", o_ERR_CNT, exp_cnt); end
    i_M0_CYC = 0; i_M0_STB = 0;
    step();
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    i_M0_CYC = 1; i_M0_STB = 1;
    step();
    for (int i = 0; i < 300 * TO + 32 && pulses < 300; i++) begin
      if (o_M0_ERR === 1'b1) begin
        pulses++;
        exp_cnt = model_sat(exp_cnt);
        step();
        n_vec++; if (o_ERR_CNT !== exp_cnt) begin n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", pulses, o_ERR_CNT, exp_cnt); end
      end else begin
        step();
      end
    end
    n_vec++; if (pulses !== 300) begin n_err++; $display("FAIL sat_pulses: got %0d want 300", pulses); end
    n_vec++; if (o_ERR_CNT !== 8'd255) begin n_err++; $display("FAIL sat_final: got %0d want 255", o_ERR_CNT); end
    i_M0_CYC = 0; i_M0_STB = 0;
    step();
  endtask

  task automatic test_reset_mid();
    i_M1_CYC = 1; i_M1_STB = 1;
    step();
    n_vec++; if (o_GNT !== 2'b10 || o_S_STB !== 1'b1) begin n_err++; $display("FAIL rm_pre: got gnt %b stb %b want 10 1", o_GNT, o_S_STB); end
    #1 i_RSTN = 1'b0;
    #1;
    n_vec++; if (o_S_CYC !== 1'b0 || o_S_STB !== 1'b0 || o_GNT !== 2'b00) begin n_err++; $display("FAIL rm_async: got cyc %b stb %b gnt %b want 0 0 00", o_S_CYC, o_S_STB, o_GNT); end
    n_vec++; if (o_ERR_CNT !== 8'd0) begin n_err++; $display("FAIL rm_errcnt: got %0d want 0", o_ERR_CNT); end
    i_M0_CYC = 1; i_M0_STB = 1;
    #1 i_RSTN = 1'b1;
    step();
    n_vec++; if (o_GNT !== 2'b01) begin n_err++; $display("FAIL rm_restart: got %b want 01", o_GNT); end
    i_M0_CYC = 0; i_M0_STB = 0; i_M1_CYC = 0; i_M1_STB = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_timeout();
    test_ack_at_limit();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_bus_arbiter.md
UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles a granted strobe waits for slave ACK (range 2..65535).
REQ-004 SHALL have i_CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have i_RSTN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have, per master m in {0,1}: i_Mm_CYC, i_Mm_STB, i_Mm_WE  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-007 SHALL have, per master: i_Mm_ADDR  input  ADDR_WIDTH; i_Mm_DATA  input  DATA_WIDTH; i_Mm_SEL  input  4  Wishbone request fields.
REQ-008 SHALL have, per master: o_Mm_DATA  output  DATA_WIDTH; o_Mm_ACK  output  1; o_Mm_ERR  output  1  response fields.
REQ-009 SHALL have slave port o_S_CYC, o_S_STB, o_S_WE  output  1; o_S_ADDR  output  ADDR_WIDTH; o_S_DATA  output  DATA_WIDTH; o_S_SEL  output  4.
REQ-010 SHALL have i_S_DATA  input  DATA_WIDTH; i_S_ACK  input  1  UART slave response.
REQ-011 SHALL have o_GNT  output  2  one-hot current grant (bit m = master m); o_ERR_CNT  output  8  timeout count.

Function
REQ-012 SHALL implement FSM states IDLE, GNT0, GNT1, registered.
REQ-013 SHALL define req_m = i_Mm_CYC & i_Mm_STB.
REQ-014 In IDLE with only req_m set, SHALL move to GNTm next cycle.
REQ-015 In IDLE with both set, SHALL grant the master not granted last (round-robin); after reset, master 0 wins first.
REQ-016 In GNTm SHALL hold the grant while i_Mm_CYC=1 (bus lock across multiple strobes), regardless of the other master.
REQ-017 In GNTm with i_Mm_CYC=0 SHALL return to IDLE, record m as last granted; minimum one IDLE cycle between tenures.
REQ-018 In GNTm, slave outputs SHALL combinationally mirror master m fields; o_S_STB additionally forced 0 during a timeout cycle.
REQ-019 In IDLE, o_S_CYC, o_S_STB, o_S_WE SHALL be 0; o_S_ADDR, o_S_DATA, o_S_SEL SHALL be 0.
REQ-020 o_Mm_ACK SHALL equal i_S_ACK & (state==GNTm); o_Mm_DATA SHALL equal i_S_DATA when granted, else 0.
REQ-021 Non-granted master SHALL see ACK=0, ERR=0, DATA=0 (stalls until granted).
REQ-022 Wait counter (16 bit) SHALL clear when i_S_ACK=1, when granted STB=0, or in IDLE; otherwise increment each cycle.
REQ-023 When wait counter reaches TIMEOUT-1 with i_S_ACK=0, o_Mm_ERR SHALL pulse 1 for one cycle, o_S_STB forced 0 that cycle, counter cleared.
REQ-024 ACK and timeout in same cycle: ACK wins, no ERR, o_ERR_CNT unchanged.
REQ-025 o_ERR_CNT SHALL increment on each ERR pulse, saturating at 255 (no wrap).
REQ-026 Master dropping CYC same cycle as ACK SHALL still receive that ACK; FSM goes IDLE next cycle.
REQ-027 o_GNT SHALL be 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE; never 2'b11.

Reset
REQ-028 While i_RSTN=0, SHALL immediately (asynchronously) force state IDLE, last-granted = master 1, wait counter 0, o_ERR_CNT 0.
REQ-029 Reset values: all o_S_* 0, all o_Mm_ACK/ERR 0, o_Mm_DATA 0, o_GNT 2'b00.
REQ-030 Reset asserted mid-tenure SHALL drop o_S_CYC/o_S_STB same instant; after release, arbitration restarts with master-0 priority.

Verification
REQ-031 Single master: M0 reads, slave ACKs 1 cycle after STB with i_S_DATA=0x41 -> o_GNT=01, o_M0_ACK=1, o_M0_DATA=0x00000041, IDLE after CYC drop.
REQ-032 Contention: both request from IDLE after reset -> M0 granted; M0 drops CYC; next arbitration with both requesting -> M1 granted.
REQ-033 Lock: M0 holds CYC for 3 writes (0x48,0x69,0x0A) while M1 requests -> all 3 reach slave in order, M1 ACK=0 until M0 releases.
REQ-034 Timeout: TIMEOUT=8, slave never ACKs -> o_M0_ERR pulses once 8 cycles after STB, o_S_STB low that cycle, o_ERR_CNT=1.
REQ-035 ACK on cycle TIMEOUT-1 -> ACK delivered, no ERR; 300 forced timeouts -> o_ERR_CNT saturates at 255.
REQ-036 Assert i_RSTN=0 mid-strobe between clock edges -> o_S_CYC/o_S_STB 0 before next edge; o_GNT=00.
